// File: rtl/uart_rx_deser.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-word holding register.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig_rx,
  output logic [DATA_WIDTH-1:0] data_rx,
  output logic                  valid_rx,
  input  logic                  ready_rx,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err,
  output logic [2:0]            dbg_state_o
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CW               = $clog2(PULSE_WIDTH) + 1;
  localparam int IW               = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] FULL_LOAD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(HALF_PULSE_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  frame_err_q, overrun_q, overrun_d;
  logic                  frame_good, frame_bad, parity_bad_evt;
  logic                  cnt_zero;

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], sig_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_bad_q, parity_bad_d;
  logic parity_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_bad_evt;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    idx_d          = idx_q;
    shift_d        = shift_q;
    frame_good     = 1'b0;
    frame_bad      = 1'b0;
    parity_bad_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d   = parity_bad_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = FULL_LOAD;
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d[idx_q] = rx_s;
          cnt_d          = FULL_LOAD;
          if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Even parity: data ones plus parity bit must be even.
          parity_bad_d = (^shift_q) ^ rx_s;
          cnt_d        = FULL_LOAD;
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s) begin
          frame_bad = 1'b1;
          state_d   = ST_BREAK;
`ifdef UART_RX_PARITY_EN
        end else if (parity_bad_q) begin
          parity_bad_evt = 1'b1;
          state_d        = ST_IDLE;
`endif
        end else begin
          frame_good = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake: a word transfers on any rising edge with valid_rx && ready_rx;
  // valid_rx then drops unless a new good frame lands on the same edge, and
  // data_rx is held while valid_rx is high without a transfer.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (frame_good) begin
      if (valid_q && !ready_rx) begin
        overrun_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready_rx) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_bad;
      overrun_q   <= overrun_d;
    end
  end

  assign data_rx     = data_q;
  assign valid_rx    = valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at 10 clocks per bit; parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_deser;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BREAK = 3'd5;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       sig_rx = 1'b1;
  logic       ready_rx = 1'b1;
  logic [7:0] data_rx;
  logic       valid_rx, frame_err, overrun, parity_err;
  logic [2:0] dbg_state;

  uart_rx_deser #(
    .DATA_WIDTH(8),
    .BAUD_RATE (100_000),
    .CLK_FREQ  (1_000_000)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sig_rx     (sig_rx),
    .data_rx    (data_rx),
    .valid_rx   (valid_rx),
    .ready_rx   (ready_rx),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  int         valid_cyc = 0, ferr_cnt = 0, ovr_cnt = 0, par_cnt = 0;
  int         rise_cyc = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (valid_rx) begin
      valid_cyc <= valid_cyc + 1;
      if (!valid_prev) rise_cyc <= cyc;
    end
    valid_prev <= valid_rx;
    if (valid_rx && ready_rx) got_q.push_back(data_rx);
    if (frame_err)  ferr_cnt <= ferr_cnt + 1;
    if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    if (parity_err) par_cnt  <= par_cnt + 1;
  end

  int checks = 0, failures = 0;
  int vb, fb, ob, pb, start_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    vb = valid_cyc; fb = ferr_cnt; ob = ovr_cnt; pb = par_cnt;
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    got_q.delete();
    exp_q.delete();
  endtask

  // driver: start, 8 data bits LSB first, optional parity, stop held stop_len clocks
  task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                            input logic stop_b, input int stop_len, input int rst_bit);
    @(posedge clk); #1;
    start_cyc = cyc;
    sig_rx = 1'b0;
    tick(10);
    for (int i = 0; i < 8; i++) begin
      sig_rx = d[i];
      if (i == rst_bit) begin
        tick(5);
        rstn = 1'b0;
        tick(2);
        check("rst_valid", valid_rx, 0);
        check("rst_data", data_rx, 0);
        check("rst_errs", {frame_err, overrun, parity_err}, 0);
        check("rst_state", dbg_state, S_IDLE);
        rstn = 1'b1;
        sig_rx = 1'b1;
        return;
      end
      tick(10);
    end
    if (par_en) begin
      sig_rx = par_bit;
      tick(10);
    end
    sig_rx = stop_b;
    tick(stop_len);
  endtask

  task automatic idle(input int n);
    sig_rx = 1'b1;
    tick(n);
  endtask

  initial begin
    tick(3);
    rstn = 1'b1;
    tick(3);
    check("reset_valid", valid_rx, 0);
    check("reset_data", data_rx, 0);
    check("reset_errs", {frame_err, overrun, parity_err}, 0);
    check("reset_state", dbg_state, S_IDLE);

    // good frame and latency from start edge
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 10, -1);
    idle(5);
    drain("a5");
    check("a5_valid_cycles", valid_cyc - vb, 1);
    check("a5_errs", (ferr_cnt - fb) + (ovr_cnt - ob) + (par_cnt - pb), 0);
    check("a5_latency_ok", ((rise_cyc - start_cyc) >= 96) && ((rise_cyc - start_cyc) <= 100), 1);

    // start-bit glitch then a clean frame
    snap();
    sig_rx = 1'b0;
    tick(3);
    idle(20);
    check("glitch_valid", valid_cyc - vb, 0);
    check("glitch_errs", (ferr_cnt - fb) + (ovr_cnt - ob) + (par_cnt - pb), 0);
    check("glitch_state", dbg_state, S_IDLE);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 10, -1);
    idle(5);
    drain("3c");

    // bad stop bit held low
    snap();
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 20, -1);
    check("brk_state", dbg_state, S_BREAK);
    check("brk_frame_err", ferr_cnt - fb, 1);
    check("brk_valid", valid_cyc - vb, 0);
    idle(5);
    check("brk_recover_state", dbg_state, S_IDLE);
    check("brk_other_errs", (ovr_cnt - ob) + (par_cnt - pb), 0);
    drain("brk");

    // overrun with consumer stalled
    ready_rx = 1'b0;
    snap();
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 10, -1);
    idle(5);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 10, -1);
    idle(5);
    check("ovr_valid_held", valid_rx, 1);
    check("ovr_data_held", data_rx, 8'h11);
    check("ovr_pulses", ovr_cnt - ob, 1);
    check("ovr_ferr", ferr_cnt - fb, 0);
    exp_q.push_back(8'h11);
    ready_rx = 1'b1;
    tick(2);
    check("ovr_valid_cleared", valid_rx, 0);
    drain("ovr");

    // reset mid-frame, then a fresh frame
    snap();
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 10, 4);
    idle(20);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 10, -1);
    idle(5);
    drain("post_rst");
    check("post_rst_errs", (ferr_cnt - fb) + (ovr_cnt - ob) + (par_cnt - pb), 0);

`ifdef UART_RX_PARITY_EN
    snap();
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 10, -1);
    idle(5);
    drain("par_ok");
    check("par_ok_err", par_cnt - pb, 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 10, -1);
    idle(5);
    check("par_bad_pulse", par_cnt - pb, 1);
    check("par_bad_valid", valid_cyc - vb, 0);
    check("par_bad_ferr", ferr_cnt - fb, 0);
    drain("par_bad");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
